// File: rtl/matrix_mult_seq_mac.sv
// Sequential matrix multiplier C = A x B (M x K times K x N) using a single
// multiply-accumulate unit, one product per cycle, with signed/unsigned and wrap/saturate modes.
module matrix_mult_seq_mac #(
    parameter int MAX_SIZE   = 10,
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [DIM_WIDTH-1:0]                     rows_a,
    input  logic [DIM_WIDTH-1:0]                     inner,
    input  logic [DIM_WIDTH-1:0]                     cols_b,
    input  logic                                     signed_mode,
    input  logic                                     sat_mode,
    input  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]  A,
    input  logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]  B,
    output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0]  C,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     err
);

    localparam int NELEM  = MAX_SIZE * MAX_SIZE;
    localparam int ADDR_W = $clog2(NELEM);
    localparam int PROD_W = 2 * DATA_WIDTH + 2;
    localparam int ACC_W  = 2 * DATA_WIDTH + 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  a_q [NELEM];
    logic [DATA_WIDTH-1:0]  b_q [NELEM];
    logic [DATA_WIDTH-1:0]  c_q [NELEM];
    logic [DIM_WIDTH-1:0]   m_q, k_dim_q, n_q;
    logic [DIM_WIDTH-1:0]   i_q, j_q, k_q;
    logic [ACC_W-1:0]       acc_q;
    logic                   signed_q, sat_q;
    logic                   busy_q, done_q, err_q;

    logic                   accept;
    logic                   dims_bad;
    logic [ADDR_W-1:0]      a_idx, b_idx, c_idx;
    logic [DATA_WIDTH-1:0]  a_el, b_el;
    logic signed [DATA_WIDTH:0] a_x, b_x;
    logic signed [PROD_W-1:0]   prod;
    logic [ACC_W-1:0]       acc_d;
    logic [DATA_WIDTH-1:0]  fit_d;
    logic                   k_last, j_last, i_last;

    assign accept   = (state_q == IDLE) && start;
    assign dims_bad = (rows_a == '0) || (rows_a > DIM_WIDTH'(MAX_SIZE)) ||
                      (inner  == '0) || (inner  > DIM_WIDTH'(MAX_SIZE)) ||
                      (cols_b == '0) || (cols_b > DIM_WIDTH'(MAX_SIZE));

    // NOTE: operand copies carry no reset; every accept reloads them before RUN reads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int e = 0; e < NELEM; e++) begin
                a_q[e] <= A[e*DATA_WIDTH +: DATA_WIDTH];
                b_q[e] <= B[e*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign a_idx = ADDR_W'(i_q) * ADDR_W'(MAX_SIZE) + ADDR_W'(k_q);
    assign b_idx = ADDR_W'(k_q) * ADDR_W'(MAX_SIZE) + ADDR_W'(j_q);
    assign c_idx = ADDR_W'(i_q) * ADDR_W'(MAX_SIZE) + ADDR_W'(j_q);
    assign a_el  = a_q[a_idx];
    assign b_el  = b_q[b_idx];

    // One extra top bit (sign copy or zero) lets a single signed multiplier serve both modes.
    assign a_x   = {signed_q & a_el[DATA_WIDTH-1], a_el};
    assign b_x   = {signed_q & b_el[DATA_WIDTH-1], b_el};
    assign prod  = PROD_W'(a_x) * PROD_W'(b_x);
    assign acc_d = ((k_q == '0) ? '0 : acc_q) + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    assign k_last = (k_q == k_dim_q - DIM_WIDTH'(1));
    assign j_last = (j_q == n_q - DIM_WIDTH'(1));
    assign i_last = (i_q == m_q - DIM_WIDTH'(1));

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        fit_d = acc_d[DATA_WIDTH-1:0];
        if (sat_q) begin
            if (signed_q) begin
                if (acc_d[ACC_W-1:DATA_WIDTH-1] != {(ACC_W-DATA_WIDTH+1){acc_d[ACC_W-1]}}) begin
                    fit_d = acc_d[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
                end
            end else if (acc_d[ACC_W-1:DATA_WIDTH] != '0) begin
                fit_d = '1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            m_q      <= '0;
            k_dim_q  <= '0;
            n_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            signed_q <= 1'b0;
            sat_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int e = 0; e < NELEM; e++) begin
                c_q[e] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q      <= rows_a;
                        k_dim_q  <= inner;
                        n_q      <= cols_b;
                        signed_q <= signed_mode;
                        sat_q    <= sat_mode;
                        i_q      <= '0;
                        j_q      <= '0;
                        k_q      <= '0;
                        acc_q    <= '0;
                        // Clearing here makes every entry outside M x N read zero.
                        for (int e = 0; e < NELEM; e++) begin
                            c_q[e] <= '0;
                        end
                        if (dims_bad) begin
                            state_q <= DONE;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!k_last) begin
                        acc_q <= acc_d;
                        k_q   <= k_q + DIM_WIDTH'(1);
                    end else begin
                        c_q[c_idx] <= fit_d;
                        k_q        <= '0;
                        if (!j_last) begin
                            j_q <= j_q + DIM_WIDTH'(1);
                        end else begin
                            j_q <= '0;
                            if (!i_last) begin
                                i_q <= i_q + DIM_WIDTH'(1);
                            end else begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NELEM; g++) begin : g_c_out
        assign C[g*DATA_WIDTH +: DATA_WIDTH] = c_q[g];
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_matrix_mult_seq_mac.sv
// Directed bench for matrix_mult_seq_mac: hand-computed results, cycle timing,
// saturation boundaries, invalid dimensions and control corner cases.
module tb_matrix_mult_seq_mac;

    localparam int MS = 10;
    localparam int DW = 32;
    localparam int NE = MS * MS;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        rows_a, inner, cols_b;
    logic              signed_mode, sat_mode;
    logic [NE*DW-1:0]  A, B;
    logic [NE*DW-1:0]  C;
    logic              busy, done, err;

    logic [DW-1:0]     exp_c [NE];
    int                n_asserts = 0;
    int                n_fail    = 0;
    int                cyc, bcnt;

    matrix_mult_seq_mac #(.MAX_SIZE(MS), .DATA_WIDTH(DW), .DIM_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rows_a(rows_a), .inner(inner), .cols_b(cols_b),
        .signed_mode(signed_mode), .sat_mode(sat_mode),
        .A(A), .B(B), .C(C),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_a(input int i, input int k, input logic [31:0] v);
        A[(i*MS+k)*DW +: DW] = v;
    endtask

    task automatic set_b(input int k, input int j, input logic [31:0] v);
        B[(k*MS+j)*DW +: DW] = v;
    endtask

    task automatic fill_ops(input logic [31:0] v);
        for (int e = 0; e < NE; e++) begin
            A[e*DW +: DW] = v;
            B[e*DW +: DW] = v;
        end
    endtask

    task automatic clear_ops(input logic [31:0] v);
        fill_ops(v);
        for (int e = 0; e < NE; e++) exp_c[e] = '0;
    endtask

    task automatic check_c(input string tag);
        for (int e = 0; e < NE; e++)
            check($sformatf("%s C[%0d][%0d]", tag, e / MS, e % MS), C[e*DW +: DW], exp_c[e]);
    endtask

    task automatic load_t1();
        clear_ops(32'h55);
        set_a(0, 0, 1); set_a(0, 1, 2); set_a(1, 0, 3); set_a(1, 1, 4);
        set_b(0, 0, 5); set_b(0, 1, 6); set_b(1, 0, 7); set_b(1, 1, 8);
        exp_c[0] = 19; exp_c[1] = 22; exp_c[MS] = 43; exp_c[MS+1] = 50;
    endtask

    task automatic load_t2();
        logic [31:0] bv [8];
        logic [31:0] cv [12];
        bv = '{1, 0, 2, 1, 0, 1, 1, 2};
        cv = '{1, 2, 4, 5, 3, 4, 10, 11, 5, 6, 16, 17};
        clear_ops(32'h0);
        for (int i = 0; i < 3; i++) begin
            set_a(i, 0, 32'(2*i+1));
            set_a(i, 1, 32'(2*i+2));
        end
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 4; j++) set_b(k, j, bv[k*4+j]);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++) exp_c[i*MS+j] = cv[i*4+j];
    endtask

    // Presents a request and returns just after the accept edge with start released.
    task automatic request(input int m, input int k, input int n, input bit sgn, input bit sat);
        @(negedge clk);
        rows_a = 8'(m); inner = 8'(k); cols_b = 8'(n);
        signed_mode = sgn; sat_mode = sat;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after the accept edge until done; start is pulsed in cycle pulse_at.
    task automatic wait_done(input int pulse_at, output int c, output int bc);
        bit seen;
        seen = 1'b0;
        c = 0;
        bc = 0;
        while (!seen && c < 400) begin
            @(negedge clk);
            c++;
            if (busy) bc++;
            if (done) seen = 1'b1;
            start = (c == pulse_at);
        end
        check("done seen", 32'(seen), 32'd1);
        @(negedge clk);
        start = 1'b0;
        check("done single cycle", 32'(done), 32'd0);
        check("idle after done", 32'(busy), 32'd0);
    endtask

    task automatic one_by_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input bit sgn, input bit sat, input logic [31:0] expv);
        clear_ops(32'h0);
        set_a(0, 0, a);
        set_b(0, 0, b);
        exp_c[0] = expv;
        request(1, 1, 1, sgn, sat);
        wait_done(0, cyc, bcnt);
        check({tag, " latency"}, 32'(cyc), 32'd2);
        check_c(tag);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; start = 1'b0;
        rows_a = '0; inner = '0; cols_b = '0;
        signed_mode = 1'b0; sat_mode = 1'b0;
        A = '0; B = '0;
        clear_ops(32'h0);
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check_c("reset");
        rst = 1'b0;

        load_t1();
        request(2, 2, 2, 1'b0, 1'b0);
        wait_done(0, cyc, bcnt);
        check("2x2x2 done cycle", 32'(cyc), 32'd9);
        check("2x2x2 busy cycles", 32'(bcnt), 32'd8);
        check("2x2x2 err", 32'(err), 32'd0);
        check_c("2x2x2");

        load_t2();
        request(3, 2, 4, 1'b0, 1'b0);
        wait_done(0, cyc, bcnt);
        check("3x2x4 done cycle", 32'(cyc), 32'd25);
        check("3x2x4 busy cycles", 32'(bcnt), 32'd24);
        check_c("3x2x4");

        clear_ops(32'h0);
        set_a(0, 0, 32'hFFFF_FFFD); set_a(0, 1, 32'd2);
        set_b(0, 0, 32'd4);         set_b(1, 0, 32'hFFFF_FFFB);
        exp_c[0] = 32'hFFFF_FFEA;
        request(1, 2, 1, 1'b1, 1'b0);
        wait_done(0, cyc, bcnt);
        check("signed done cycle", 32'(cyc), 32'd3);
        check_c("signed");

        one_by_one("s sat pos", 32'h7FFF_FFFF, 32'd2, 1'b1, 1'b1, 32'h7FFF_FFFF);
        one_by_one("s wrap", 32'h7FFF_FFFF, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFE);
        one_by_one("u sat", 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFF);
        one_by_one("u wrap", 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 32'hFFFF_FFFE);
        one_by_one("s sat neg", 32'h8000_0000, 32'd2, 1'b1, 1'b1, 32'h8000_0000);
        one_by_one("s sat minsq", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h7FFF_FFFF);
        one_by_one("s sat in range", 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFE);

        clear_ops(32'h11);
        request(2, 0, 2, 1'b0, 1'b0);
        wait_done(0, cyc, bcnt);
        check("inner=0 done cycle", 32'(cyc), 32'd1);
        check("inner=0 busy cycles", 32'(bcnt), 32'd0);
        check("inner=0 err held", 32'(err), 32'd1);
        check_c("inner=0");
        request(2, 2, 11, 1'b0, 1'b0);
        wait_done(0, cyc, bcnt);
        check("cols=11 done cycle", 32'(cyc), 32'd1);
        check("cols=11 busy cycles", 32'(bcnt), 32'd0);
        check("cols=11 err held", 32'(err), 32'd1);
        check_c("cols=11");
        clear_ops(32'h0);
        set_a(0, 0, 32'd3); set_b(0, 0, 32'd5);
        exp_c[0] = 32'd15;
        request(1, 1, 1, 1'b0, 1'b0);
        check("err cleared at accept", 32'(err), 32'd0);
        wait_done(0, cyc, bcnt);
        check("valid after err", 32'(err), 32'd0);
        check_c("valid after err");

        load_t1();
        request(2, 2, 2, 1'b0, 1'b0);
        fill_ops(32'h77);
        rows_a = 8'd1; inner = 8'd1; cols_b = 8'd1; sat_mode = 1'b1;
        wait_done(4, cyc, bcnt);
        check("mid-run start done cycle", 32'(cyc), 32'd9);
        check("mid-run start busy", 32'(bcnt), 32'd8);
        check_c("mid-run start");

        load_t1();
        request(2, 2, 2, 1'b0, 1'b0);
        wait_done(9, cyc, bcnt);
        check("done-cycle start done", 32'(cyc), 32'd9);
        @(negedge clk);
        check("done-cycle start ignored", 32'(busy), 32'd0);
        check_c("done-cycle start");

        load_t2();
        request(3, 2, 4, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("busy before reset", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        clear_ops(32'h0);
        check("mid-run reset busy", 32'(busy), 32'd0);
        check("mid-run reset done", 32'(done), 32'd0);
        check_c("mid-run reset");
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("no activity after reset", 32'(pulses), 32'd0);
        load_t1();
        request(2, 2, 2, 1'b0, 1'b0);
        wait_done(0, cyc, bcnt);
        check("post-reset done cycle", 32'(cyc), 32'd9);
        check_c("post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_mult_seq_mac.md
Name: matrix_mult_seq_mac

Overview:
Sequential, start/done-driven successor to the combinational flat-bus matrix multiplier. It computes C = A × B for non-square operands: A is rows_a × inner, B is inner × cols_b, with each dimension in 1..MAX_SIZE. A single multiply-accumulate unit performs one product per cycle. The block adds signed/unsigned operand modes and wrap/saturate result modes. It sits between the operand-loading logic and the result consumer, and replaces the combinational multiplier where timing closure matters.

Parameters:
MAX_SIZE, 10, maximum value of any dimension; every matrix is stored as MAX_SIZE×MAX_SIZE, row-major.
DATA_WIDTH, 32, element width of A, B and C.
DIM_WIDTH, 8, width of the dimension ports; must satisfy 2^DIM_WIDTH > MAX_SIZE.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request a multiply; sampled only in IDLE.
rows_a  in  DIM_WIDTH  M, the number of rows of A and C.
inner  in  DIM_WIDTH  K, the columns of A and the rows of B.
cols_b  in  DIM_WIDTH  N, the number of columns of B and C.
signed_mode  in  1  1 = operands and result are two's complement; 0 = unsigned.
sat_mode  in  1  1 = saturate each C element; 0 = truncate (wrap).
A  in  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened A; element (i,k) sits at bit offset (i*MAX_SIZE+k)*DATA_WIDTH.
B  in  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened B, same layout.
C  out  MAX_SIZE*MAX_SIZE*DATA_WIDTH  flattened result, same layout; registered.
busy  out  1  high while in RUN.
done  out  1  single-cycle completion pulse.
err  out  1  high if the last accepted request had an invalid dimension; held until the next accepted start.

Behaviour:
- Reset (asynchronous): state=IDLE; C=0, busy=0, done=0, err=0; index counters and accumulator cleared. Reset during RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE with start=1 at an edge (accept edge):
  - latch A, B, M, K, N, signed_mode and sat_mode; clear C and err; set i=j=k=0.
  - if any dimension is 0 or greater than MAX_SIZE: go to DONE with err=1.
  - otherwise go to RUN.
- start asserted in RUN or DONE is ignored; it is not queued. Inputs may change freely after the accept edge.
- RUN: one MAC per cycle on the latched operands.
  - prod = A[i][k]*B[k][j], a full 2*DATA_WIDTH product, signed or unsigned per the mode.
  - sum = (k==0 ? 0 : acc) + prod, held in a 2*DATA_WIDTH+8 bit accumulator, so the sum never overflows internally.
  - if k<K-1: acc<=sum, k<=k+1.
  - if k==K-1: write C[i][j]<=fit(sum), then set k=0 and advance j; after j==N-1, set j=0 and advance i.
  - the cycle that writes C[M-1][N-1] transitions to DONE.
- RUN length is exactly M*K*N cycles. busy=1 throughout RUN and 0 otherwise.
- DONE: lasts one cycle with done=1, then returns to IDLE. A start asserted in that DONE cycle is ignored.
- Latency: done is high in the cycle M*K*N+1 after the accept edge, and 1 cycle after it for an invalid request.
- fit(sum):
  - wrap mode: low DATA_WIDTH bits.
  - sat mode, unsigned: values above 2^DATA_WIDTH-1 clamp to all ones.
  - sat mode, signed: clamp to the range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- C entries with i≥M or j≥N read 0.
- C holds its value from the DONE cycle until the next accept edge, or reset.
- C is not guaranteed meaningful while busy=1: entries are written progressively.

Test Plan:
- Unsigned wrap, 2×2×2, A=[1 2;3 4], B=[5 6;7 8] -> C=[19 22;43 50]; done exactly 9 cycles after the accept edge; busy high for 8 cycles; all other C entries 0.
- Non-square, M=3, K=2, N=4, A rows=[1 2],[3 4],[5 6], B rows=[1 0 2 1],[0 1 1 2] -> C rows=[1 2 4 5],[3 4 10 11],[5 6 16 17]; done at cycle 25.
- Signed mode, 1×2×1, A=[-3 2], B=[4 -5] (two's complement) -> C[0][0]=-22 (0xFFFFFFEA).
- Overflow, 1×1×1, A=0x7FFFFFFF, B=2:
  - signed saturate -> 0x7FFFFFFF.
  - signed wrap -> 0xFFFFFFFE.
  - unsigned saturate, A=0xFFFFFFFF -> 0xFFFFFFFF.
- Invalid dimensions, inner=0 and separately cols_b=11 -> no RUN; done and err=1 one cycle after accept; C all 0. A following valid request clears err.
- Control corner cases:
  - start pulsed mid-RUN -> ignored; result unchanged.
  - rst asserted mid-RUN -> C=0, busy=0, no done pulse.
  - a new start after that reset -> completes normally.
